// File: rtl/rdma_pkg.sv
// Shared definitions for the RDMA ingress arbiter: source encodings,
// arbiter state encoding and default beat width.
package rdma_pkg;

  localparam int DEFAULT_DATA_W = 64;

  localparam logic SRC_HOST = 1'b1;
  localparam logic SRC_RX   = 1'b0;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rdma_ingress_arb_if.sv
// Beat-stream bundle around the ingress arbiter: two unbackpressured input
// streams, the merged output stream and the drop/truncation pulses.
interface rdma_ingress_arb_if #(
  parameter int DATA_W = rdma_pkg::DEFAULT_DATA_W
);
  logic              host_valid;
  logic [DATA_W-1:0] host_data;
  logic              host_last;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_last;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_src;
  logic              drop_host;
  logic              drop_rx;
  logic              trunc;

  modport master (
    output host_valid, host_data, host_last,
    output rx_valid, rx_data, rx_last,
    input  out_valid, out_data, out_last, out_src,
    input  drop_host, drop_rx, trunc
  );

  modport slave (
    input  host_valid, host_data, host_last,
    input  rx_valid, rx_data, rx_last,
    output out_valid, out_data, out_last, out_src,
    output drop_host, drop_rx, trunc
  );
endinterface

// File: rtl/rdma_pkt_fifo.sv
// Per-source packet FIFO with whole-packet admission, truncation of overlong
// packets and a count of complete packets ready for the arbiter.
module rdma_pkt_fifo
  import rdma_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_PKT_BEATS = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic              head_last_o,
  output logic              pkt_avail_o,
  output logic              drop_o,
  output logic              trunc_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [IW-1:0] ONE_I = IW'(1);

  logic [DATA_W-1:0]     data_mem_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] last_mem_q;
  logic [CW-1:0]         wr_ptr_q, rd_ptr_q, pkt_cnt_q;
  logic                  in_pkt_q, drop_q, drop_pulse_q, trunc_pulse_q;
  logic [IW-1:0]         beat_idx_q;

  logic [CW-1:0] used, free;
  logic [IW-1:0] cur_idx;
  logic          admit, full, empty, wr_en, forced_last, wr_last, do_pop;

  assign used  = wr_ptr_q - rd_ptr_q;
  assign free  = CW'(FIFO_DEPTH) - used;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // Admission is decided on the first beat only, against the pre-read free count.
  always_comb begin
    admit       = (free >= CW'(MAX_PKT_BEATS));
    cur_idx     = in_pkt_q ? beat_idx_q : '0;
    wr_en       = 1'b0;
    if (in_valid_i) begin
      wr_en = in_pkt_q ? !drop_q : admit;
    end
    wr_en       = wr_en && !full;
    forced_last = wr_en && !in_last_i && (cur_idx == IW'(MAX_PKT_BEATS - 1));
    wr_last     = in_last_i || forced_last;
    do_pop      = pop_i && !empty;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem_q[wr_ptr_q[AW-1:0]] <= in_data_i;
      last_mem_q[wr_ptr_q[AW-1:0]] <= wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      pkt_cnt_q     <= '0;
      in_pkt_q      <= 1'b0;
      drop_q        <= 1'b0;
      beat_idx_q    <= '0;
      drop_pulse_q  <= 1'b0;
      trunc_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q  <= in_valid_i && !in_pkt_q && !admit;
      trunc_pulse_q <= forced_last;
      if (wr_en) wr_ptr_q <= wr_ptr_q + ONE_C;
      if (do_pop) rd_ptr_q <= rd_ptr_q + ONE_C;
      unique case ({wr_en && wr_last, do_pop && head_last_o})
        2'b10:   pkt_cnt_q <= pkt_cnt_q + ONE_C;
        2'b01:   pkt_cnt_q <= pkt_cnt_q - ONE_C;
        default: pkt_cnt_q <= pkt_cnt_q;
      endcase
      // A forced last or a rejection discards the rest of the packet.
      if (in_valid_i) begin
        if (in_last_i) begin
          in_pkt_q   <= 1'b0;
          drop_q     <= 1'b0;
          beat_idx_q <= '0;
        end else begin
          in_pkt_q   <= 1'b1;
          drop_q     <= !wr_en || forced_last;
          beat_idx_q <= cur_idx + ONE_I;
        end
      end
    end
  end

  assign head_data_o = data_mem_q[rd_ptr_q[AW-1:0]];
  assign head_last_o = last_mem_q[rd_ptr_q[AW-1:0]];
  assign pkt_avail_o = (pkt_cnt_q != '0);
  assign drop_o      = drop_pulse_q;
  assign trunc_o     = trunc_pulse_q;

endmodule

// File: rtl/rdma_ingress_arb.sv
// Packet-atomic round-robin arbiter merging the host and rx streams into one
// contiguous beat stream for qp_context.
module rdma_ingress_arb
  import rdma_pkg::*;
#(
  parameter int DATA_W        = DEFAULT_DATA_W,
  parameter int FIFO_DEPTH    = 16,
  parameter int MAX_PKT_BEATS = 8
) (
  input logic clk,
  input logic rst,
  rdma_ingress_arb_if.slave bus
);
  logic [DATA_W-1:0] host_head, rx_head, sel_data;
  logic              host_head_last, rx_head_last, sel_last;
  logic              host_avail, rx_avail, host_pop, rx_pop;
  logic              host_drop, rx_drop, host_trunc, rx_trunc;
  logic              pick;

  arb_state_e        state_q;
  logic              last_grant_q;
  logic              out_valid_q, out_last_q, out_src_q;
  logic [DATA_W-1:0] out_data_q;

  assign host_pop = (state_q == ARB_SEND) && (last_grant_q == SRC_HOST);
  assign rx_pop   = (state_q == ARB_SEND) && (last_grant_q == SRC_RX);

  rdma_pkt_fifo #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_PKT_BEATS(MAX_PKT_BEATS)
  ) u_host_fifo (
    .clk(clk), .rst(rst),
    .in_valid_i(bus.host_valid), .in_data_i(bus.host_data), .in_last_i(bus.host_last),
    .pop_i(host_pop), .head_data_o(host_head), .head_last_o(host_head_last),
    .pkt_avail_o(host_avail), .drop_o(host_drop), .trunc_o(host_trunc)
  );

  rdma_pkt_fifo #(
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_PKT_BEATS(MAX_PKT_BEATS)
  ) u_rx_fifo (
    .clk(clk), .rst(rst),
    .in_valid_i(bus.rx_valid), .in_data_i(bus.rx_data), .in_last_i(bus.rx_last),
    .pop_i(rx_pop), .head_data_o(rx_head), .head_last_o(rx_head_last),
    .pkt_avail_o(rx_avail), .drop_o(rx_drop), .trunc_o(rx_trunc)
  );

  // On a tie the source that did not win last time gets the grant.
  always_comb begin
    pick = SRC_RX;
    if (host_avail && rx_avail) pick = ~last_grant_q;
    else if (host_avail)        pick = SRC_HOST;
    sel_data = (last_grant_q == SRC_HOST) ? host_head : rx_head;
    sel_last = (last_grant_q == SRC_HOST) ? host_head_last : rx_head_last;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= SRC_RX;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_src_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
          out_last_q  <= 1'b0;
          out_src_q   <= 1'b0;
          if (host_avail || rx_avail) begin
            state_q      <= ARB_SEND;
            last_grant_q <= pick;
          end
        end
        ARB_SEND: begin
          out_valid_q <= 1'b1;
          out_data_q  <= sel_data;
          out_last_q  <= sel_last;
          out_src_q   <= last_grant_q;
          if (sel_last) state_q <= ARB_IDLE;
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
  assign bus.drop_host = host_drop;
  assign bus.drop_rx   = rx_drop;
  assign bus.trunc     = host_trunc || rx_trunc;

endmodule

// File: tb/tb_rdma_ingress_arb.sv
// Bench for rdma_ingress_arb: directed scenarios plus random traffic, all
// compared cycle by cycle against a queue-based packet model.
`timescale 1ns/1ps
module tb_rdma_ingress_arb;
  import rdma_pkg::*;

  localparam int DATA_W = 64;
  localparam int DEPTH  = 16;
  localparam int MAXB   = 8;

  typedef struct packed { logic [DATA_W-1:0] d; logic l; } beat_t;
  typedef struct { bit v; logic [DATA_W-1:0] d; bit l; } stim_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rdma_ingress_arb_if #(.DATA_W(DATA_W)) ifc();

  rdma_ingress_arb #(
    .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .MAX_PKT_BEATS(MAXB)
  ) dut (
    .clk(clk), .rst(rst), .bus(ifc)
  );

  int total = 0;
  int bad   = 0;

  stim_t hostStim[$];
  stim_t rxStim[$];

  // Reference model: per-source beat queues and packet counts, index 1=host, 0=rx
  beat_t mq [2][$];
  int    mPkts [2];
  bit    mInPkt [2];
  bit    mDrop [2];
  int    mIdx [2];
  bit    mBusy = 1'b0;
  int    mGnt  = 0;
  logic              expValid = 1'b0, expLast = 1'b0, expSrc = 1'b0;
  logic [DATA_W-1:0] expData  = '0;
  logic              expDropH = 1'b0, expDropR = 1'b0, expTrunc = 1'b0;

  wire [DATA_W+5:0] gotVec  = {ifc.out_valid, ifc.out_last, ifc.out_src, ifc.out_data,
                               ifc.drop_host, ifc.drop_rx, ifc.trunc};
  wire [DATA_W+5:0] wantVec = {expValid, expLast, expSrc, expData, expDropH, expDropR, expTrunc};

  task automatic modelStep();
    bit v [2];
    logic [DATA_W-1:0] d [2];
    bit l [2];
    int freeSnap [2];
    int pktsSnap [2];
    bit dropP [2];
    bit tr;
    beat_t b;
    v[1] = ifc.host_valid; d[1] = ifc.host_data; l[1] = ifc.host_last;
    v[0] = ifc.rx_valid;   d[0] = ifc.rx_data;   l[0] = ifc.rx_last;
    if (rst) begin
      for (int s = 0; s < 2; s++) begin
        mq[s].delete(); mPkts[s] = 0; mInPkt[s] = 0; mDrop[s] = 0; mIdx[s] = 0;
      end
      mBusy = 0; mGnt = 0;
      expValid = 0; expLast = 0; expSrc = 0; expData = '0;
      expDropH = 0; expDropR = 0; expTrunc = 0;
      return;
    end
    for (int s = 0; s < 2; s++) begin
      freeSnap[s] = DEPTH - mq[s].size();
      pktsSnap[s] = mPkts[s];
    end
    expValid = 0; expLast = 0; expSrc = 0; expData = '0;
    if (mBusy) begin
      b = mq[mGnt].pop_front();
      expValid = 1; expData = b.d; expLast = b.l; expSrc = (mGnt == 1);
      if (b.l) begin
        mPkts[mGnt]--;
        mBusy = 0;
      end
    end else if (pktsSnap[0] > 0 || pktsSnap[1] > 0) begin
      if (pktsSnap[0] > 0 && pktsSnap[1] > 0) mGnt = 1 - mGnt;
      else mGnt = (pktsSnap[1] > 0) ? 1 : 0;
      mBusy = 1;
    end
    tr = 0;
    for (int s = 0; s < 2; s++) begin
      dropP[s] = 0;
      if (v[s]) begin
        if (!mInPkt[s]) begin
          mInPkt[s] = 1;
          mIdx[s]   = 0;
          mDrop[s]  = (freeSnap[s] < MAXB);
          dropP[s]  = mDrop[s];
        end
        if (!mDrop[s] && mIdx[s] < MAXB) begin
          b.d = d[s];
          b.l = l[s] || (mIdx[s] == MAXB - 1);
          if (b.l && !l[s]) tr = 1;
          mq[s].push_back(b);
          if (b.l) mPkts[s]++;
        end
        mIdx[s]++;
        if (l[s]) mInPkt[s] = 0;
      end
    end
    expDropH = dropP[1];
    expDropR = dropP[0];
    expTrunc = tr;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      modelStep();
    end
  end

  task automatic idleInputs();
    ifc.host_valid = 0; ifc.host_data = '0; ifc.host_last = 0;
    ifc.rx_valid   = 0; ifc.rx_data   = '0; ifc.rx_last   = 0;
  endtask

  task automatic pushIdle(input bit isHost, input int n);
    stim_t e;
    e.v = 0; e.d = '0; e.l = 0;
    for (int i = 0; i < n; i++) begin
      if (isHost) hostStim.push_back(e); else rxStim.push_back(e);
    end
  endtask

  task automatic pushPkt(input bit isHost, input int n, input logic [DATA_W-1:0] base);
    stim_t e;
    for (int i = 0; i < n; i++) begin
      e.v = 1; e.d = base + DATA_W'(i); e.l = (i == n - 1);
      if (isHost) hostStim.push_back(e); else rxStim.push_back(e);
    end
  endtask

  task automatic applyStimulus();
    stim_t e;
    idleInputs();
    if (hostStim.size() > 0) begin
      e = hostStim.pop_front();
      ifc.host_valid = e.v; ifc.host_data = e.d; ifc.host_last = e.l;
    end
    if (rxStim.size() > 0) begin
      e = rxStim.pop_front();
      ifc.rx_valid = e.v; ifc.rx_data = e.d; ifc.rx_last = e.l;
    end
  endtask

  task automatic doReset();
    hostStim.delete(); rxStim.delete();
    idleInputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    hostStim.delete(); rxStim.delete();
    idleInputs();
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (gotVec !== wantVec) begin
        bad++; $display("[TB] FAIL reset_model cyc=%0d got=%h want=%h", k, gotVec, wantVec);
      end
      total++;
      if ({ifc.out_valid, ifc.out_last, ifc.drop_host, ifc.drop_rx, ifc.trunc} !== 5'b0) begin
        bad++; $display("[TB] FAIL reset_outputs cyc=%0d got=%b want=00000", k,
                        {ifc.out_valid, ifc.out_last, ifc.drop_host, ifc.drop_rx, ifc.trunc});
      end
    end
    rst = 0;
  endtask

  task automatic test_host_alone();
    int firstIter = -1, beats = 0, lastAt = 0;
    doReset();
    pushPkt(1, 3, 64'hA0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      total++;
      if (gotVec !== wantVec) begin
        bad++; $display("[TB] FAIL host_alone_model cyc=%0d got=%h want=%h", k, gotVec, wantVec);
      end
      if (ifc.out_valid) begin
        if (firstIter < 0) firstIter = k;
        total++;
        if (ifc.out_data !== 64'hA0 + DATA_W'(beats) || ifc.out_src !== 1'b1) begin
          bad++; $display("[TB] FAIL host_alone_beat got=%h/%b want=%h/1", ifc.out_data, ifc.out_src,
                          64'hA0 + DATA_W'(beats));
        end
        beats++;
        if (ifc.out_last) lastAt = beats;
      end
      applyStimulus();
    end
    total++;
    if (firstIter != 5 || beats != 3 || lastAt != 3) begin
      bad++; $display("[TB] FAIL host_alone_timing got first=%0d beats=%0d lastAt=%0d want 5/3/3",
                      firstIter, beats, lastAt);
    end
  endtask

  task automatic test_tie();
    logic [3:0] srcSeq = '0, lastSeq = '0;
    int beats = 0;
    doReset();
    pushPkt(1, 2, 64'hB0);
    pushPkt(0, 2, 64'hC0);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      total++;
      if (gotVec !== wantVec) begin
        bad++; $display("[TB] FAIL tie_model cyc=%0d got=%h want=%h", k, gotVec, wantVec);
      end
      if (ifc.out_valid) begin
        srcSeq  = {srcSeq[2:0], ifc.out_src};
        lastSeq = {lastSeq[2:0], ifc.out_last};
        beats++;
      end
      applyStimulus();
    end
    total++;
    if (beats != 4 || srcSeq !== 4'b1100 || lastSeq !== 4'b0101) begin
      bad++; $display("[TB] FAIL tie_order got beats=%0d src=%b last=%b want 4/1100/0101",
                      beats, srcSeq, lastSeq);
    end
  endtask

  task automatic test_stream();
    int prevSrc = -1;
    doReset();
    for (int i = 0; i < 20; i++) begin
      pushPkt(1, 1, 64'h1000 + DATA_W'(i));
      pushPkt(0, 1, 64'h2000 + DATA_W'(i));
    end
    for (int k = 0; k < 90; k++) begin
      @(negedge clk);
      total++;
      if (gotVec !== wantVec) begin
        bad++; $display("[TB] FAIL stream_model cyc=%0d got=%h want=%h", k, gotVec, wantVec);
      end
      if (k <= 10) begin
        total++;
        if (ifc.drop_host !== 1'b0 || ifc.drop_rx !== 1'b0) begin
          bad++; $display("[TB] FAIL stream_early_drop cyc=%0d got=%b%b want=00", k, ifc.drop_host, ifc.drop_rx);
        end
      end
      if (ifc.out_valid && k < 20) begin
        total++;
        if (prevSrc < 0 ? (ifc.out_src !== 1'b1) : (int'(ifc.out_src) == prevSrc)) begin
          bad++; $display("[TB] FAIL stream_alternate cyc=%0d got src=%b prev=%0d", k, ifc.out_src, prevSrc);
        end
        prevSrc = int'(ifc.out_src);
      end
      applyStimulus();
    end
  endtask

  task automatic test_trunc();
    int beats = 0, lastAt = 0, truncs = 0;
    doReset();
    pushPkt(0, 11, 64'hD0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      total++;
      if (gotVec !== wantVec) begin
        bad++; $display("[TB] FAIL trunc_model cyc=%0d got=%h want=%h", k, gotVec, wantVec);
      end
      if (ifc.trunc) truncs++;
      if (ifc.out_valid) begin
        total++;
        if (ifc.out_data !== 64'hD0 + DATA_W'(beats) || ifc.out_src !== 1'b0) begin
          bad++; $display("[TB] FAIL trunc_beat got=%h/%b want=%h/0", ifc.out_data, ifc.out_src,
                          64'hD0 + DATA_W'(beats));
        end
        beats++;
        if (ifc.out_last) lastAt = beats;
      end
      applyStimulus();
    end
    total++;
    if (beats != 8 || lastAt != 8 || truncs != 1) begin
      bad++; $display("[TB] FAIL trunc_summary got beats=%0d lastAt=%0d truncs=%0d want 8/8/1",
                      beats, lastAt, truncs);
    end
  endtask

  task automatic test_drop();
    int hostBeats = 0, rxBeats = 0, drops = 0, ghost = 0;
    logic [DATA_W-1:0] dv;
    doReset();
    pushPkt(0, 8, 64'hE0);
    pushIdle(1, 4);
    pushPkt(1, 5, 64'h100);
    pushPkt(1, 5, 64'h200);
    pushPkt(1, 3, 64'hDD00);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      total++;
      if (gotVec !== wantVec) begin
        bad++; $display("[TB] FAIL drop_model cyc=%0d got=%h want=%h", k, gotVec, wantVec);
      end
      if (ifc.drop_host) drops++;
      if (ifc.out_valid) begin
        dv = ifc.out_data;
        if (ifc.out_src) hostBeats++; else rxBeats++;
        if (dv[15:8] == 8'hDD) ghost++;
      end
      applyStimulus();
    end
    total++;
    if (drops != 1 || hostBeats != 10 || rxBeats != 8 || ghost != 0) begin
      bad++; $display("[TB] FAIL drop_summary got drops=%0d host=%0d rx=%0d ghost=%0d want 1/10/8/0",
                      drops, hostBeats, rxBeats, ghost);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0, rstAt = -1, fresh = 0, freshLast = 0;
    doReset();
    pushPkt(1, 4, 64'hF0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      total++;
      if (gotVec !== wantVec) begin
        bad++; $display("[TB] FAIL reset_mid_model cyc=%0d got=%h want=%h", k, gotVec, wantVec);
      end
      if (rstAt >= 0 && k == rstAt + 1) begin
        total++;
        if (ifc.out_valid !== 1'b0) begin
          bad++; $display("[TB] FAIL reset_mid_valid got=%b want=0", ifc.out_valid);
        end
        rst = 0;
        pushPkt(1, 2, 64'h3A0);
      end
      if (ifc.out_valid) begin
        beats++;
        if (rstAt >= 0) begin
          total++;
          if (ifc.out_data !== 64'h3A0 + DATA_W'(fresh)) begin
            bad++; $display("[TB] FAIL reset_mid_fresh got=%h want=%h", ifc.out_data, 64'h3A0 + DATA_W'(fresh));
          end
          fresh++;
          if (ifc.out_last) freshLast = fresh;
        end
      end
      if (rstAt < 0 && beats == 2) begin
        rst = 1;
        rstAt = k;
      end
      applyStimulus();
    end
    total++;
    if (fresh != 2 || freshLast != 2) begin
      bad++; $display("[TB] FAIL reset_mid_summary got fresh=%0d last=%0d want 2/2", fresh, freshLast);
    end
  endtask

  task automatic test_random();
    doReset();
    for (int s = 0; s < 2; s++) begin
      while ((s == 1 ? hostStim.size() : rxStim.size()) < 220) begin
        pushPkt(s == 1, int'($urandom_range(1, 11)), {$urandom, $urandom});
        pushIdle(s == 1, int'($urandom_range(0, 6)));
      end
    end
    for (int k = 0; k < 320; k++) begin
      @(negedge clk);
      total++;
      if (gotVec !== wantVec) begin
        bad++; $display("[TB] FAIL random_model cyc=%0d got=%h want=%h", k, gotVec, wantVec);
      end
      applyStimulus();
    end
  endtask

  initial begin
    idleInputs();
    test_reset();
    test_host_alone();
    test_tie();
    test_stream();
    test_trunc();
    test_drop();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
